// File: rtl/jk_cmd_sequencer.sv
// Command FIFO plus a three-state issue FSM that drives a downstream JK flip-flop at most once
// every two cycles. Define JK_SEQ_CHECK_EN to enable the q_fb check behind the mismatch flag.
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       j,
  output logic       k,
  output logic       jk_strobe,
  input  logic       q_fb,
  output logic       q_exp,
  output logic       busy,
  output logic       mismatch
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIssue  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("jk_cmd_sequencer: DEPTH must be a power of two and at least 2");
  end

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          j_q, j_d;
  logic          k_q, k_d;
  logic          strobe_q, strobe_d;
  logic          q_exp_q, q_exp_d;
  logic          push, pop, empty;

  // Ready comes from the registered count only, so a pop while full frees space a cycle later.
  assign cmd_ready = (count_q != CountFull);
  assign empty     = (count_q == '0);
  assign push      = cmd_valid & cmd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd;
    end
  end

  always_comb begin
    state_d  = state_q;
    j_d      = 1'b0;
    k_d      = 1'b0;
    strobe_d = 1'b0;
    q_exp_d  = q_exp_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle, StSettle: begin
        if (!empty) begin
          pop        = 1'b1;
          state_d    = StIssue;
          {j_d, k_d} = mem_q[rd_ptr_q];
          strobe_d   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        state_d = StSettle;
        // Mirror what the flip-flop does as it samples j/k on this edge.
        unique case ({j_q, k_q})
          2'b01:   q_exp_d = 1'b0;
          2'b10:   q_exp_d = 1'b1;
          2'b11:   q_exp_d = ~q_exp_q;
          default: q_exp_d = q_exp_q;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      strobe_q <= 1'b0;
      q_exp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      j_q      <= j_d;
      k_q      <= k_d;
      strobe_q <= strobe_d;
      q_exp_q  <= q_exp_d;
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign jk_strobe = strobe_q;
  assign q_exp     = q_exp_q;
  assign busy      = (state_q != StIdle) || !empty;

`ifdef JK_SEQ_CHECK_EN
  logic mismatch_q;

  // In SETTLE the flip-flop has already taken the issued command, so q_fb must equal q_exp.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_q <= 1'b0;
    end else if (state_q == StSettle && q_fb != q_exp_q) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: vector table plus scoreboard of expected strobes, with a
// behavioural JK flip-flop downstream feeding q_fb.
module tb_jk_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
`ifdef JK_SEQ_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd       = 2'b00;
  logic       cmd_ready, j, k, jk_strobe, q_fb, q_exp, busy, mismatch;
  logic       ff_q;
  logic       force_q0 = 1'b0;

  typedef struct {
    logic [1:0] cmd;
    logic       j;
    logic       k;
    logic       q;
  } vec_t;

  typedef struct {
    logic j;
    logic k;
    logic q;
  } exp_t;

  vec_t tbl [9];
  exp_t sb [$];
  exp_t cur;
  int   strobe_times [$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   strobe_cnt  = 0;
  int   cycle       = 0;
  logic pending     = 1'b0;
  logic model_q     = 1'b0;
  logic last_j      = 1'b0;
  logic last_k      = 1'b0;

  jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .j         (j),
    .k         (k),
    .jk_strobe (jk_strobe),
    .q_fb      (q_fb),
    .q_exp     (q_exp),
    .busy      (busy),
    .mismatch  (mismatch)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  // Downstream flip-flop on the same clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ff_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign q_fb = force_q0 ? 1'b0 : ff_q;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input logic [1:0] c);
    exp_t e;
    case (c)
      2'b01:   model_q = 1'b0;
      2'b10:   model_q = 1'b1;
      2'b11:   model_q = ~model_q;
      default: model_q = model_q;
    endcase
    e.j = c[1];
    e.k = c[0];
    e.q = model_q;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic offer(input logic [1:0] c, output int waits);
    waits     = 0;
    cmd       = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && waits < 50) begin
      @(negedge clock);
      waits++;
    end
    if (!cmd_ready) check("offer_timeout", int'(cmd_ready), 1);
    else sb_push(c);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) check("idle_timeout", int'(busy), 0);
  endtask

  task automatic assert_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    sb.delete();
    model_q   = 1'b0;
    pending   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_j"}, int'(j), 0);
    check({tag, "_k"}, int'(k), 0);
    check({tag, "_strobe"}, int'(jk_strobe), 0);
    check({tag, "_q_exp"}, int'(q_exp), 0);
    check({tag, "_mismatch"}, int'(mismatch), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
  endtask

  // Scoreboard monitor: each strobe pops one expected command; the following cycle checks
  // that j/k dropped and q_exp took the modelled value.
  always @(negedge clock) begin
    if (reset_n) begin
      if (jk_strobe) begin
        strobe_cnt++;
        strobe_times.push_back(cycle);
        last_j = j;
        last_k = k;
        if (sb.size() == 0) begin
          check("unexpected_strobe", int'(jk_strobe), 0);
        end else begin
          cur = sb.pop_front();
          check("strobe_j", int'(j), int'(cur.j));
          check("strobe_k", int'(k), int'(cur.k));
          pending = 1'b1;
        end
      end else if (pending) begin
        check("settle_jk", int'({j, k}), 0);
        check("settle_q_exp", int'(q_exp), int'(cur.q));
        pending = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, t0, w;
    tbl[0] = '{cmd: 2'b10, j: 1'b1, k: 1'b0, q: 1'b1};
    tbl[1] = '{cmd: 2'b11, j: 1'b1, k: 1'b1, q: 1'b0};
    tbl[2] = '{cmd: 2'b11, j: 1'b1, k: 1'b1, q: 1'b1};
    tbl[3] = '{cmd: 2'b01, j: 1'b0, k: 1'b1, q: 1'b0};
    tbl[4] = '{cmd: 2'b00, j: 1'b0, k: 1'b0, q: 1'b0};
    tbl[5] = '{cmd: 2'b10, j: 1'b1, k: 1'b0, q: 1'b1};
    tbl[6] = '{cmd: 2'b00, j: 1'b0, k: 1'b0, q: 1'b1};
    tbl[7] = '{cmd: 2'b11, j: 1'b1, k: 1'b1, q: 1'b0};
    tbl[8] = '{cmd: 2'b01, j: 1'b0, k: 1'b1, q: 1'b0};

    assert_reset();
    #2;
    check_reset_values("por");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Single commands from idle, including hold slots.
    for (int i = 0; i < 9; i++) begin
      s0 = strobe_cnt;
      offer(tbl[i].cmd, w);
      wait_idle();
      check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, 1);
      check($sformatf("vec%0d_j", i), int'(last_j), int'(tbl[i].j));
      check($sformatf("vec%0d_k", i), int'(last_k), int'(tbl[i].k));
      check($sformatf("vec%0d_q_exp", i), int'(q_exp), int'(tbl[i].q));
    end

    // Back-to-back 10,11,11,01: strobes two cycles apart.
    s0 = strobe_cnt;
    t0 = strobe_times.size();
    offer(2'b10, w);
    offer(2'b11, w);
    offer(2'b11, w);
    offer(2'b01, w);
    wait_idle();
    check("b2b_strobes", strobe_cnt - s0, 4);
    if (strobe_times.size() >= t0 + 4) begin
      for (int i = 1; i < 4; i++) begin
        check($sformatf("b2b_spacing%0d", i), strobe_times[t0 + i] - strobe_times[t0 + i - 1], 2);
      end
    end
    check("b2b_q_exp", int'(q_exp), 0);

    // Fill: one accept per cycle against one pop per two cycles reaches full on the 7th accept.
    s0 = strobe_cnt;
    offer(2'b10, w);
    offer(2'b11, w);
    offer(2'b00, w);
    offer(2'b01, w);
    offer(2'b11, w);
    offer(2'b10, w);
    offer(2'b11, w);
    check("full_ready", int'(cmd_ready), 0);
    check("full_busy", int'(busy), 1);
    offer(2'b01, w);
    check("full_offer_waits", w, 1);
    check("refull_ready", int'(cmd_ready), 0);
    wait_idle();
    check("fill_strobes", strobe_cnt - s0, 8);
    check("fill_q_exp", int'(q_exp), int'(model_q));
    check("fill_sb_empty", sb.size(), 0);

    // Reset while in ISSUE with three commands still queued.
    for (int i = 0; i < 6; i++) offer(2'b11, w);
    check("pre_reset_strobe", int'(jk_strobe), 1);
    #2;
    assert_reset();
    #1;
    check_reset_values("midrst");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    s0 = strobe_cnt;
    repeat (12) @(negedge clock);
    check("post_reset_strobes", strobe_cnt - s0, 0);
    check("post_reset_busy", int'(busy), 0);

    // Feedback check: q_fb forced low after a set command.
    check("pre_force_mismatch", int'(mismatch), 0);
    force_q0 = 1'b1;
    offer(2'b10, w);
    wait_idle();
    check("force_mismatch", int'(mismatch), int'(EXP_MM));
    force_q0 = 1'b0;
    offer(2'b01, w);
    wait_idle();
    check("sticky_mismatch", int'(mismatch), int'(EXP_MM));
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
